// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks every input vector of a small combinational gate,
// holds each one long enough to settle, checks the gate output against a
// reference reduction and reports the mismatch count, first failing vector
// and an overall pass flag.
module gate_sweep_ctrl #(
    parameter int N_IN       = 2,   // gate inputs, sweep covers 2^N_IN vectors
    parameter int SETTLE_CYC = 2,   // cycles each vector is held before sampling
    parameter int EXP_OP     = 0    // 0:&  1:|  2:^  3:~&
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    output logic [N_IN-1:0] gate_in_o,
    input  logic            gate_y_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN:0]   err_count_o,
    output logic            fail_valid_o,
    output logic [N_IN-1:0] first_fail_vec_o
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [7:0]      WAIT_LD  = 8'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      wait_q, wait_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] ffv_q, ffv_d;
    logic            pass_q, pass_d;
    logic            exp_y;

    // Reference value the gate should produce for the vector on its inputs
    always_comb begin
        case (EXP_OP)
            1:       exp_y = |vec_q;
            2:       exp_y = ^vec_q;
            3:       exp_y = ~&vec_q;
            default: exp_y = &vec_q;
        endcase
    end

    // Sequencer: next state and next value of every result register
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    vec_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffv_d   = '0;
                    pass_d  = 1'b0;
                    wait_d  = WAIT_LD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (wait_q == 8'd0) state_d = CHECK;
                else                wait_d  = wait_q - 8'd1;
            end
            CHECK: begin
                if (gate_y_i != exp_y) begin
                    err_d = err_q + (N_IN+1)'(1);
                    if (!fv_q) begin
                        ffv_d = vec_q;
                        fv_d  = 1'b1;
                    end
                end
                // equality compare on the last vector so the counter never wraps
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    wait_d  = WAIT_LD;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort overrides everything; partial error results are kept
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            vec_d   = '0;
            pass_d  = 1'b0;
            wait_d  = wait_q;
            err_d   = err_q;
            fv_d    = fv_q;
            ffv_d   = ffv_q;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffv_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign gate_in_o        = vec_q;
    assign busy_o           = (state_q == SETTLE) || (state_q == CHECK);
    assign done_o           = (state_q == DONE);
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign fail_valid_o     = fv_q;
    assign first_fail_vec_o = ffv_q;

endmodule
